// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
// Scan state enum, active-high hex font {g,f,e,d,c,b,a}, blank/off codes.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_scan_ctrl_hex.sv
// hex_to_seg7: combinational nibble to active-low segment decode.
// Ports: nib_i (hex digit), seg_n_o ({g,f,e,d,c,b,a}, active-low).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_0;
    unique case (nib_i)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
      default: pat = SEG_0;
    endcase
  end

  assign seg_n_o = ~pat;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode scan with guard time and shadow.
// Ports: clk, rst_n, en, digit_data/dp_in/blank_mask, upd_req/upd_ack,
// an_n, seg_n, dp_n, frame_done. Option: LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digit_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam bit NO_GUARD = (GUARD_CYCLES == 0);

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;

  logic [15:0] sh_data_q;
  logic [3:0]  sh_dp_q;
  logic [3:0]  sh_blank_q;

  logic [3:0]  an_n_q;
  logic [6:0]  seg_n_q;
  logic        dp_n_q;
  logic        ack_q;
  logic        fd_q;

  logic       drive_last;
  logic       guard_last;
  logic       wrap;
  logic       show;
  logic       dark;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic [3:0] lz;

  assign drive_last = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
  assign guard_last = (cnt_q == CNT_W'(GLAST));

  // Leaving digit 3's slot closes the frame.
  assign wrap = en && (idx_q == 2'd3) &&
                ((state_q == GUARD && guard_last) ||
                 (state_q == DRIVE && drive_last && NO_GUARD));

  assign show    = en && (state_q == DRIVE);
  assign cur_nib = sh_data_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic n3z, n2z, n1z;
  assign n3z = (sh_data_q[15:12] == 4'h0);
  assign n2z = (sh_data_q[11:8]  == 4'h0);
  assign n1z = (sh_data_q[7:4]   == 4'h0);
  // Digit 0 is never suppressed so a zero value still reads "0".
  assign lz  = {n3z, n3z & n2z, n3z & n2z & n1z, 1'b0};
`else
  assign lz  = 4'b0000;
`endif

  assign dark = sh_blank_q[idx_q] | lz[idx_q];

  hex_to_seg7 u_hex (
    .nib_i   (cur_nib),
    .seg_n_o (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      an_n_q     <= AN_OFF;
      seg_n_q    <= SEG_BLANK;
      dp_n_q     <= 1'b1;
      ack_q      <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      an_n_q  <= show ? ~(4'b0001 << idx_q) : AN_OFF;
      seg_n_q <= (show && !dark) ? cur_seg : SEG_BLANK;
      dp_n_q  <= ~(show && !dark && sh_dp_q[idx_q]);
      fd_q    <= wrap;
      ack_q   <= wrap && upd_req;

      if (wrap && upd_req) begin
        sh_data_q  <= digit_data;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_mask;
      end

      if (!en) begin
        state_q <= OFF;
        idx_q   <= 2'd0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          OFF: begin
            state_q <= DRIVE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
          end
          DRIVE: begin
            if (drive_last) begin
              cnt_q <= '0;
              if (NO_GUARD) begin
                idx_q <= idx_q + 2'd1;
              end else begin
                state_q <= GUARD;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          GUARD: begin
            if (guard_last) begin
              cnt_q   <= '0;
              state_q <= DRIVE;
              idx_q   <= idx_q + 2'd1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= OFF;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign upd_ack    = ack_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench for seg7_scan_ctrl against
// a frame-position reference model (DIGIT_CYCLES=4, GUARD_CYCLES=1).
module tb_seg7_scan_ctrl;

  localparam int DC     = 4;
  localparam int GC     = 1;
  localparam int SLOT   = DC + GC;
  localparam int PERIOD = 4 * SLOT;

  // Active-high {g,f,e,d,c,b,a} font, index 0..F.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digit_data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  seg7_scan_ctrl #(
    .DIGIT_CYCLES (DC),
    .GUARD_CYCLES (GC),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: pos = scan position of the DUT state (-1 = not scanning).
  int          pos = -1;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;
  int          ncyc = 0;
  int          last_fd = -1;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit lz_dark(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d > 0) && ((m_data >> (d * 4)) == 16'h0);
`else
    return (d < 0);
`endif
  endfunction

  // Called just after a negedge with inputs settled for the next edge.
  task automatic cyc();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, e_ack, ack_seen;
    logic [3:0] nib;
    int         sl, wi;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    e_fd = 1'b0; e_ack = 1'b0;
    if (!en) begin
      pos = -1;
      last_fd = -1;
    end else if (pos < 0) begin
      pos = 0;
    end else begin
      sl = pos / SLOT;
      wi = pos % SLOT;
      if (wi < DC) begin
        e_an[sl] = 1'b0;
        nib = m_data[sl*4 +: 4];
        if (!m_blank[sl] && !lz_dark(sl)) begin
          e_seg = ~FONT[nib];
          e_dp  = ~m_dp[sl];
        end
      end
      if (pos == PERIOD - 1) begin
        e_fd = 1'b1;
        if (upd_req) begin
          e_ack   = 1'b1;
          m_data  = digit_data;
          m_dp    = dp_in;
          m_blank = blank_mask;
        end
      end
      pos = (pos + 1) % PERIOD;
    end
    @(posedge clk);
    #1;
    ncyc++;
    chk("an_n", {12'h0, an_n}, {12'h0, e_an});
    chk("seg_n", {9'h0, seg_n}, {9'h0, e_seg});
    chk("dp_n", {15'h0, dp_n}, {15'h0, e_dp});
    chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
    chk("upd_ack", {15'h0, upd_ack}, {15'h0, e_ack});
    if (frame_done) begin
      if (last_fd >= 0)
        chk("fd_period", 16'(ncyc - last_fd), 16'(PERIOD));
      last_fd = ncyc;
    end
    ack_seen = upd_ack;
    @(negedge clk);
    if (ack_seen) upd_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Asynchronous reset asserted between edges, released at a negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {12'h0, an_n}, 16'h000F);
    chk("rst_seg", {9'h0, seg_n}, 16'h007F);
    chk("rst_dp", {15'h0, dp_n}, 16'h0001);
    chk("rst_fd", {15'h0, frame_done}, 16'h0000);
    chk("rst_ack", {15'h0, upd_ack}, 16'h0000);
    pos = -1;
    m_data = '0; m_dp = '0; m_blank = '0;
    last_fd = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pos(input string tag, input int target);
    bit found = 0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      cyc();
      found = (pos == target);
    end
    chk(tag, {15'h0, found}, 16'h0001);
  endtask

  task automatic request(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bm);
    digit_data = d;
    dp_in      = dp;
    blank_mask = bm;
    upd_req    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_an0", {12'h0, an_n}, 16'h000F);
    chk("rst_seg0", {9'h0, seg_n}, 16'h007F);
    rst_n = 1'b1;
    @(negedge clk);

    // Load 1234 at the first boundary, then scan it.
    en = 1'b1;
    request(16'h1234, 4'h0, 4'h0);
    run(3 * PERIOD);

    // Mid-frame update to ABCD.
    run(7);
    request(16'hABCD, 4'h0, 4'h0);
    run(2 * PERIOD);

    // Blank digit 2, decimal point on digit 0.
    request(16'hABCD, 4'b0001, 4'b0100);
    run(2 * PERIOD);

    // Drop en while digit 2 is driven, then restart.
    wait_pos("wait_d2", 2 * SLOT + 1);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(PERIOD + 3);

    // Reset during a guard slot; shadow must read 0 afterwards.
    request(16'h5678, 4'hF, 4'h0);
    run(2 * PERIOD);
    wait_pos("wait_guard", SLOT + DC);
    do_reset();
    run(PERIOD + 2);

`ifdef LEADING_ZERO_BLANK_EN
    request(16'h0070, 4'h0, 4'h0);
    run(2 * PERIOD);
    request(16'h0000, 4'h0, 4'h0);
    run(2 * PERIOD);
`endif

    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(999);
      if (r < 3) begin
        do_reset();
      end else if (!en) begin
        if ($urandom_range(3) == 0) en = 1'b1;
      end else if (r < 10) begin
        en = 1'b0;
      end
      if (!upd_req && $urandom_range(39) == 0)
        request(16'($urandom), 4'($urandom), 4'($urandom));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
